// File: rtl/scan_mem_loader_pkg.sv
// Shared types and header field layout for the scan-chain memory loader.
package scan_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        CHECK  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_CSUM  = 2'd1,
        ERR_ABORT = 2'd2,
        ERR_BANK  = 2'd3
    } err_e;

    function automatic int bank_width(input int num_banks);
        return (num_banks <= 2) ? 1 : $clog2(num_banks);
    endfunction

    function automatic int hdr_base_lsb();
        return 0;
    endfunction

    function automatic int hdr_count_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int hdr_bank_lsb(input int addr_w);
        return 2 * addr_w;
    endfunction

    function automatic int hdr_min_width(input int addr_w, input int bank_w);
        return 2 * addr_w + bank_w;
    endfunction

endpackage

// File: rtl/scan_mem_loader_if.sv
// Scan-side input pair plus the memory write port and frame status.
interface scan_mem_loader_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int NUM_BANKS = 4
);
    logic                 scan_in;
    logic                 scan_enable;
    logic [NUM_BANKS-1:0] mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_data;
    logic                 busy;
    logic                 done;
    logic [1:0]           err_code;

    modport master (
        input  scan_in, scan_enable,
        output mem_we, mem_addr, mem_data, busy, done, err_code
    );

    modport slave (
        output scan_in, scan_enable,
        input  mem_we, mem_addr, mem_data, busy, done, err_code
    );
endinterface

// File: rtl/scan_mem_loader_shift_reg.sv
// LSB-first deserialiser: presents the word being completed this cycle and
// flags the sample that finishes it.
module scan_shift_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic              din,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    // Only DATA_W-1 bits are stored; the final bit comes straight from din.
    logic [DATA_W-2:0] shift_r;
    logic [CNT_W-1:0]  cnt_r;

    // Shift register and wrapping bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= '0;
            cnt_r   <= '0;
        end else if (clear) begin
            shift_r <= '0;
            cnt_r   <= '0;
        end else if (enable) begin
            shift_r <= word[DATA_W-1:1];
            cnt_r   <= (cnt_r == LAST) ? '0 : cnt_r + CNT_W'(1'b1);
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    // Word assembly and completion flag for the current sample.
    always_comb begin
        word       = {din, shift_r};
        word_valid = enable && !clear && (cnt_r == LAST);
    end

endmodule

// File: rtl/scan_mem_loader.sv
// Frame decoder: header/data/checksum FSM driving registered bank writes
// and frame status.
module scan_mem_loader
    import scan_loader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int NUM_BANKS = 4
) (
    input  logic               scan_clk,
    input  logic               reset,
    scan_mem_loader_if.master  bus
);
    localparam int BANK_W   = bank_width(NUM_BANKS);
    localparam int BASE_LSB = hdr_base_lsb();
    localparam int CNT_LSB  = hdr_count_lsb(ADDR_W);
    localparam int BANK_LSB = hdr_bank_lsb(ADDR_W);

    logic [DATA_W-1:0]    word_s;
    logic                 word_valid_s;
    logic                 clear_s;
    logic [BANK_W-1:0]    hdr_bank_s;
    logic                 hdr_bank_ok_s;
    logic [NUM_BANKS-1:0] hdr_onehot_s;

    state_e               state_r;
    err_e                 err_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [ADDR_W-1:0]    remain_r;
    logic [NUM_BANKS-1:0] onehot_r;
    logic                 bank_ok_r;
    logic [DATA_W-1:0]    csum_r;
    logic [NUM_BANKS-1:0] mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [DATA_W-1:0]    mem_data_r;
    logic                 busy_r;
    logic                 done_r;

    scan_shift_reg #(.DATA_W(DATA_W)) u_shift (
        .clk        (scan_clk),
        .rst        (reset),
        .clear      (clear_s),
        .enable     (bus.scan_enable),
        .din        (bus.scan_in),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Abort detection and header bank decode.
    always_comb begin
        clear_s       = !bus.scan_enable && (state_r != IDLE);
        hdr_bank_s    = word_s[BANK_LSB +: BANK_W];
        hdr_bank_ok_s = (int'(hdr_bank_s) < NUM_BANKS);
        hdr_onehot_s  = {{(NUM_BANKS-1){1'b0}}, 1'b1} << hdr_bank_s;
    end

    // Frame FSM with address/count tracking, checksum and output registers.
    always_ff @(posedge scan_clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            err_r      <= ERR_NONE;
            addr_r     <= '0;
            remain_r   <= '0;
            onehot_r   <= '0;
            bank_ok_r  <= 1'b0;
            csum_r     <= '0;
            mem_we_r   <= '0;
            mem_addr_r <= '0;
            mem_data_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            mem_we_r <= '0;
            done_r   <= 1'b0;
            if (clear_s) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
                err_r   <= ERR_ABORT;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.scan_enable) begin
                            state_r <= HEADER;
                            busy_r  <= 1'b1;
                            err_r   <= ERR_NONE;
                        end
                    end
                    HEADER: begin
                        if (word_valid_s) begin
                            addr_r    <= word_s[BASE_LSB +: ADDR_W];
                            remain_r  <= word_s[CNT_LSB +: ADDR_W];
                            onehot_r  <= hdr_onehot_s;
                            bank_ok_r <= hdr_bank_ok_s;
                            csum_r    <= '0;
                            state_r   <= DATA;
                        end
                    end
                    DATA: begin
                        if (word_valid_s) begin
                            if (bank_ok_r) begin
                                mem_we_r   <= onehot_r;
                                mem_addr_r <= addr_r;
                                mem_data_r <= word_s;
                            end
                            addr_r <= addr_r + ADDR_W'(1'b1);
                            csum_r <= csum_r ^ word_s;
                            if (remain_r == '0) begin
                                state_r <= CHECK;
                            end else begin
                                remain_r <= remain_r - ADDR_W'(1'b1);
                            end
                        end
                    end
                    CHECK: begin
                        if (word_valid_s) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                            if (!bank_ok_r) begin
                                err_r <= ERR_BANK;
                            end else if (word_s != csum_r) begin
                                err_r <= ERR_CSUM;
                            end else begin
                                err_r <= ERR_NONE;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_we   = mem_we_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_data = mem_data_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err_code = err_r;

endmodule

// File: tb/tb_scan_mem_loader.sv
// Randomised bench for scan_mem_loader: 4-bank and 3-bank instances checked
// against a frame-level model of expected writes and status.
module tb_scan_mem_loader;

    typedef struct {
        logic [3:0]  we;
        logic [8:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    wr_t         got_w[$];
    wr_t         exp_w[$];
    logic [1:0]  got_done[$];
    logic [1:0]  exp_done[$];
    logic [31:0] frame_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    scan_mem_loader_if #(.DATA_W(32), .ADDR_W(9), .NUM_BANKS(4)) if4 ();
    scan_mem_loader_if #(.DATA_W(32), .ADDR_W(9), .NUM_BANKS(3)) if3 ();

    scan_mem_loader #(.DATA_W(32), .ADDR_W(9), .NUM_BANKS(4)) dut4 (
        .scan_clk (clk), .reset (rst), .bus (if4));
    scan_mem_loader #(.DATA_W(32), .ADDR_W(9), .NUM_BANKS(3)) dut3 (
        .scan_clk (clk), .reset (rst), .bus (if3));

    // Record every write strobe and done pulse from either instance.
    always @(negedge clk) begin
        if (if4.mem_we != 4'd0) got_w.push_back('{if4.mem_we, if4.mem_addr, if4.mem_data, cyc});
        if (if3.mem_we != 3'd0) got_w.push_back('{{1'b0, if3.mem_we}, if3.mem_addr, if3.mem_data, cyc});
        if (if4.done) got_done.push_back(if4.err_code);
        if (if3.done) got_done.push_back(if3.err_code);
    end

    task automatic drive(input bit to3, input logic en, input logic b);
        if (to3) begin if3.scan_enable = en; if3.scan_in = b; end
        else     begin if4.scan_enable = en; if4.scan_in = b; end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        if4.scan_enable = 1'b0; if3.scan_enable = 1'b0;
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input bit to3, input logic [31:0] w, input int lo, input int n);
        for (int i = lo; i < lo + n; i++) drive(to3, 1'b1, w[i]);
    endtask

    function automatic logic [31:0] hdr(input logic [8:0] base, input int count, input logic [1:0] bank);
        return 32'(base) | ((32'(count - 1) & 32'h1FF) << 9) | (32'(bank) << 18);
    endfunction

    function automatic logic [31:0] xor_all();
        logic [31:0] x = 32'd0;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        return x;
    endfunction

    // Frame-level reference: which writes a frame produces and its final status.
    function automatic void model(input bit to3, input logic [8:0] base, input int count,
                                  input logic [1:0] bank, input logic [31:0] csum);
        int nb = to3 ? 3 : 4;
        for (int i = 0; i < count; i++)
            if (int'(bank) < nb)
                exp_w.push_back('{4'b0001 << bank, 9'(int'(base) + i), frame_q[i], 0});
        if (int'(bank) >= nb)      exp_done.push_back(2'd3);
        else if (csum != xor_all()) exp_done.push_back(2'd1);
        else                        exp_done.push_back(2'd0);
    endfunction

    task automatic send_body(input bit to3, input logic [31:0] csum);
        foreach (frame_q[i]) send_word(to3, frame_q[i], 0, 32);
        send_word(to3, csum, 0, 32);
    endtask

    task automatic send_frame(input bit to3, input logic [8:0] base, input int count,
                              input logic [1:0] bank, input logic [31:0] csum);
        send_word(to3, hdr(base, count, bank), 0, 32);
        send_body(to3, csum);
    endtask

    task automatic clear_sb();
        got_w.delete(); exp_w.delete(); got_done.delete(); exp_done.delete();
    endtask

    task automatic test_reset_values();
        #7;
        n_checks++;
        if ({if4.mem_we, if4.mem_addr, if4.mem_data, if4.busy, if4.done, if4.err_code} !== 49'd0) begin
            n_fail++; $display("FAIL reset_values4: got we=%b addr=%h data=%h busy=%b done=%b err=%0d expected all 0",
                if4.mem_we, if4.mem_addr, if4.mem_data, if4.busy, if4.done, if4.err_code);
        end
        n_checks++;
        if ({if3.mem_we, if3.mem_addr, if3.mem_data, if3.busy, if3.done, if3.err_code} !== 48'd0) begin
            n_fail++; $display("FAIL reset_values3: got we=%b busy=%b err=%0d expected all 0",
                if3.mem_we, if3.busy, if3.err_code);
        end
    endtask

    task automatic test_nominal();
        clear_sb();
        frame_q = '{32'hA5A50001, 32'h000000FF, 32'h12345678};
        model(1'b0, 9'h010, 3, 2'd2, 32'hB7915686);
        send_word(1'b0, 32'h00080410, 0, 32);
        n_checks++;
        if (if4.busy !== 1'b1) begin n_fail++; $display("FAIL nominal_busy: got %b expected 1", if4.busy); end
        send_body(1'b0, 32'hB7915686);
        n_checks++;
        if ({if4.done, if4.busy, if4.err_code} !== 4'b1000) begin
            n_fail++; $display("FAIL nominal_done: got done=%b busy=%b err=%0d expected 1 0 0",
                if4.done, if4.busy, if4.err_code);
        end
        idle(3);
        n_checks++;
        if (got_w.size() != 3 || got_done.size() != 1) begin
            n_fail++; $display("FAIL nominal_counts: got %0d writes %0d dones expected 3 1", got_w.size(), got_done.size());
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            n_checks++;
            if (got_w[i].we !== exp_w[i].we || got_w[i].addr !== exp_w[i].addr || got_w[i].data !== exp_w[i].data) begin
                n_fail++; $display("FAIL nominal_write%0d: got %b@%h=%h expected %b@%h=%h", i, got_w[i].we,
                    got_w[i].addr, got_w[i].data, exp_w[i].we, exp_w[i].addr, exp_w[i].data);
            end
        end
        if (got_w.size() >= 2) begin
            n_checks++;
            if (got_w[1].cyc - got_w[0].cyc != 32) begin
                n_fail++; $display("FAIL nominal_spacing: got %0d expected 32", got_w[1].cyc - got_w[0].cyc);
            end
        end
        if (got_done.size() >= 1) begin
            n_checks++;
            if (got_done[0] !== exp_done[0]) begin
                n_fail++; $display("FAIL nominal_err: got %0d expected %0d", got_done[0], exp_done[0]);
            end
        end
    endtask

    task automatic test_csum_fail();
        clear_sb();
        frame_q = '{32'hA5A50001, 32'h000000FF, 32'h12345678};
        model(1'b0, 9'h010, 3, 2'd2, 32'h0);
        send_frame(1'b0, 9'h010, 3, 2'd2, 32'h0);
        idle(5);
        n_checks++;
        if (if4.err_code !== 2'd1) begin n_fail++; $display("FAIL csum_err_hold: got %0d expected 1", if4.err_code); end
        n_checks++;
        if (got_w.size() != exp_w.size() || got_done.size() != 1 || got_done[0] !== exp_done[0]) begin
            n_fail++; $display("FAIL csum_frame: got %0d writes %0d dones expected %0d writes err %0d",
                got_w.size(), got_done.size(), exp_w.size(), exp_done[0]);
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            n_checks++;
            if (got_w[i].addr !== exp_w[i].addr || got_w[i].data !== exp_w[i].data) begin
                n_fail++; $display("FAIL csum_write%0d: got %h=%h expected %h=%h", i,
                    got_w[i].addr, got_w[i].data, exp_w[i].addr, exp_w[i].data);
            end
        end
    endtask

    task automatic test_reset();
        clear_sb();
        rst = 1'b1; #1;
        n_checks++;
        if ({if4.err_code, if4.mem_addr, if4.mem_data} !== 43'd0) begin
            n_fail++; $display("FAIL reset_idle: got err=%0d addr=%h data=%h expected 0", if4.err_code, if4.mem_addr, if4.mem_data);
        end
        @(negedge clk); rst = 1'b0;
        send_word(1'b0, hdr(9'h020, 4, 2'd1), 0, 32);
        send_word(1'b0, 32'hCAFEF00D, 0, 32);
        n_checks++;
        if (if4.mem_we !== 4'b0010) begin n_fail++; $display("FAIL reset_prewrite: got %b expected 0010", if4.mem_we); end
        #1 rst = 1'b1; #1;
        n_checks++;
        if ({if4.mem_we, if4.mem_addr, if4.mem_data, if4.busy, if4.done, if4.err_code} !== 49'd0) begin
            n_fail++; $display("FAIL reset_midframe: got we=%b addr=%h busy=%b expected all 0", if4.mem_we, if4.mem_addr, if4.busy);
        end
        got_w.delete();
        @(negedge clk); rst = 1'b0;
        idle(40);
        n_checks++;
        if (got_w.size() != 0 || if4.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_nowrite: got %0d writes busy=%b expected 0 0", got_w.size(), if4.busy);
        end
    endtask

    task automatic test_wrap_b2b();
        logic [31:0] h2;
        logic [8:0]  base2;
        clear_sb();
        frame_q = '{$urandom, $urandom};
        model(1'b0, 9'h1FF, 2, 2'd1, xor_all() ^ 32'd1);
        send_frame(1'b0, 9'h1FF, 2, 2'd1, xor_all() ^ 32'd1);
        n_checks++;
        if ({if4.done, if4.err_code} !== 3'b101) begin
            n_fail++; $display("FAIL b2b_first_done: got done=%b err=%0d expected 1 1", if4.done, if4.err_code);
        end
        base2 = 9'($urandom);
        h2 = hdr(base2, 2, 2'd3);
        frame_q = '{$urandom, $urandom};
        model(1'b0, base2, 2, 2'd3, xor_all());
        send_word(1'b0, h2, 0, 1);
        n_checks++;
        if ({if4.busy, if4.err_code} !== 3'b100) begin
            n_fail++; $display("FAIL b2b_err_clear: got busy=%b err=%0d expected 1 0", if4.busy, if4.err_code);
        end
        send_word(1'b0, h2, 1, 31);
        send_body(1'b0, xor_all());
        idle(3);
        n_checks++;
        if (got_w.size() != exp_w.size() || got_done.size() != 2) begin
            n_fail++; $display("FAIL b2b_counts: got %0d writes %0d dones expected %0d 2", got_w.size(), got_done.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            n_checks++;
            if (got_w[i].we !== exp_w[i].we || got_w[i].addr !== exp_w[i].addr || got_w[i].data !== exp_w[i].data) begin
                n_fail++; $display("FAIL b2b_write%0d: got %b@%h=%h expected %b@%h=%h", i, got_w[i].we,
                    got_w[i].addr, got_w[i].data, exp_w[i].we, exp_w[i].addr, exp_w[i].data);
            end
        end
        foreach (got_done[i]) if (i < exp_done.size()) begin
            n_checks++;
            if (got_done[i] !== exp_done[i]) begin
                n_fail++; $display("FAIL b2b_err%0d: got %0d expected %0d", i, got_done[i], exp_done[i]);
            end
        end
    endtask

    task automatic test_bad_bank();
        clear_sb();
        frame_q = '{$urandom, $urandom, $urandom};
        model(1'b1, 9'($urandom), 3, 2'd3, xor_all());
        send_frame(1'b1, 9'h040, 3, 2'd3, xor_all());
        frame_q = '{$urandom};
        model(1'b1, 9'h000, 1, 2'd3, ~xor_all());
        send_frame(1'b1, 9'h000, 1, 2'd3, ~xor_all());
        idle(3);
        n_checks++;
        if (got_w.size() != 0 || got_done.size() != 2) begin
            n_fail++; $display("FAIL badbank_counts: got %0d writes %0d dones expected 0 2", got_w.size(), got_done.size());
        end
        foreach (got_done[i]) if (i < exp_done.size()) begin
            n_checks++;
            if (got_done[i] !== exp_done[i]) begin
                n_fail++; $display("FAIL badbank_err%0d: got %0d expected %0d", i, got_done[i], exp_done[i]);
            end
        end
    endtask

    task automatic test_abort();
        clear_sb();
        send_word(1'b0, hdr(9'h100, 2, 2'd0), 0, 32);
        send_word(1'b0, 32'hFFFFFFFF, 0, 8);
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({if4.busy, if4.done, if4.err_code} !== 4'b0010) begin
            n_fail++; $display("FAIL abort_status: got busy=%b done=%b err=%0d expected 0 0 2", if4.busy, if4.done, if4.err_code);
        end
        idle(40);
        n_checks++;
        if (got_w.size() != 0 || got_done.size() != 0) begin
            n_fail++; $display("FAIL abort_quiet: got %0d writes %0d dones expected 0 0", got_w.size(), got_done.size());
        end
        // Abort at the checksum word: the final data write still lands.
        frame_q = '{$urandom, $urandom};
        model(1'b0, 9'h0F0, 2, 2'd3, xor_all());
        exp_done.delete();
        send_word(1'b0, hdr(9'h0F0, 2, 2'd3), 0, 32);
        foreach (frame_q[i]) send_word(1'b0, frame_q[i], 0, 32);
        drive(1'b0, 1'b0, 1'b0);
        idle(2);
        n_checks++;
        if (got_w.size() != 2 || got_done.size() != 0 || if4.err_code !== 2'd2) begin
            n_fail++; $display("FAIL abort_check: got %0d writes %0d dones err=%0d expected 2 0 2",
                got_w.size(), got_done.size(), if4.err_code);
        end
        if (got_w.size() == 2) begin
            n_checks++;
            if (got_w[1].addr !== exp_w[1].addr || got_w[1].data !== exp_w[1].data) begin
                n_fail++; $display("FAIL abort_lastwrite: got %h=%h expected %h=%h",
                    got_w[1].addr, got_w[1].data, exp_w[1].addr, exp_w[1].data);
            end
        end
        clear_sb();
        frame_q = '{32'hA5A50001, 32'h000000FF, 32'h12345678};
        model(1'b0, 9'h010, 3, 2'd2, 32'hB7915686);
        send_frame(1'b0, 9'h010, 3, 2'd2, 32'hB7915686);
        idle(3);
        n_checks++;
        if (got_w.size() != 3 || got_done.size() != 1 || got_done[0] !== 2'd0) begin
            n_fail++; $display("FAIL abort_recover: got %0d writes %0d dones expected 3 writes err 0", got_w.size(), got_done.size());
        end
    endtask

    task automatic test_random();
        clear_sb();
        for (int f = 0; f < 12; f++) begin
            bit          to3   = 1'($urandom_range(0, 1));
            logic [8:0]  base  = 9'($urandom);
            int          count = $urandom_range(1, 5);
            logic [1:0]  bank  = 2'($urandom_range(0, 3));
            logic [31:0] csum;
            frame_q.delete();
            for (int i = 0; i < count; i++) frame_q.push_back($urandom);
            csum = ($urandom_range(0, 9) < 7) ? xor_all() : xor_all() ^ (32'd1 << $urandom_range(0, 31));
            model(to3, base, count, bank, csum);
            send_frame(to3, base, count, bank, csum);
            idle($urandom_range(0, 3));
        end
        idle(3);
        n_checks++;
        if (got_w.size() != exp_w.size() || got_done.size() != exp_done.size()) begin
            n_fail++; $display("FAIL random_counts: got %0d writes %0d dones expected %0d %0d",
                got_w.size(), got_done.size(), exp_w.size(), exp_done.size());
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            n_checks++;
            if (got_w[i].we !== exp_w[i].we || got_w[i].addr !== exp_w[i].addr || got_w[i].data !== exp_w[i].data) begin
                n_fail++; $display("FAIL random_write%0d: got %b@%h=%h expected %b@%h=%h", i, got_w[i].we,
                    got_w[i].addr, got_w[i].data, exp_w[i].we, exp_w[i].addr, exp_w[i].data);
            end
        end
        foreach (exp_done[i]) if (i < got_done.size()) begin
            n_checks++;
            if (got_done[i] !== exp_done[i]) begin
                n_fail++; $display("FAIL random_err%0d: got %0d expected %0d", i, got_done[i], exp_done[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if4.scan_in = 1'b0; if4.scan_enable = 1'b0;
        if3.scan_in = 1'b0; if3.scan_enable = 1'b0;
        test_reset_values();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        test_nominal();
        test_csum_fail();
        test_reset();
        test_wrap_b2b();
        test_bad_bank();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
